lane_dispatch_rr: RTL and testbench
===================================

Name: lane_dispatch_rr

Overview:
- Round-robin dispatcher that takes one valid/ready input stream and spreads items across NUM_LANES child lanes.
- Sits directly upstream of a width-5 subgroup level and feeds its five leaf instances, one lane each.
- Each lane has a one-entry output register, so lanes that stall are skipped.
- Keeps a wrapping dispatch counter and reports the lane index of the last accepted item.

Parameters:
- NUM_LANES, 5, number of downstream lanes (2..16).
- DATA_W, 8, payload width in bits.
- CNT_W, 16, width of the dispatch counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream item valid.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  dispatcher accepts this cycle.
- out_valid  output  NUM_LANES  per-lane item valid (bit i = lane i).
- out_data  output  NUM_LANES*DATA_W  per-lane payload; lane i occupies bits [i*DATA_W +: DATA_W].
- out_ready  input  NUM_LANES  per-lane downstream ready.
- disp_count  output  CNT_W  total items accepted, wrapping.
- last_lane  output  $clog2(NUM_LANES)  lane index of the most recently accepted item.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, ptr=0, disp_count=0, last_lane=0.
  - Any in-flight lane contents are discarded, even mid-handshake.
  - in_ready is forced 0 while rst=1.
- Lane free condition: free[i] = !out_valid[i] | out_ready[i].
  - A full lane being drained this cycle counts as free, giving full throughput with no bubble.
- Selection, combinational:
  - sel = first i in circular order ptr, ptr+1, ..., ptr+NUM_LANES-1 (mod NUM_LANES) with free[i]=1.
  - in_ready = |free & !rst.
- Accept when in_valid & in_ready. On the next edge:
  - Lane sel loads in_data and out_valid[sel]=1.
  - ptr <= (sel==NUM_LANES-1) ? 0 : sel+1. Wrap is explicit; no power-of-two assumption.
  - disp_count <= disp_count+1, wrapping modulo 2^CNT_W with no saturation or flag.
  - last_lane <= sel.
- No accept: ptr, disp_count and last_lane hold.
- Latency: accepted item appears on out_valid/out_data exactly 1 cycle after the accept edge. No combinational path from in_data to out_data.
- Lane drain:
  - out_valid[i] & out_ready[i] and lane i not reloaded in the same cycle -> out_valid[i] clears next cycle.
  - out_data[i] holds its last value after clearing.
- Simultaneous drain and reload of the same lane: the new item replaces the old one; out_valid[i] stays 1.
- Holding rules:
  - out_valid[i]=1 with out_ready[i]=0: out_data[i] is stable until the handshake completes.
  - out_valid never drops without a handshake, except on reset.
- All lanes full and none ready: in_ready=0, all state holds; upstream must hold in_valid/in_data.
- in_valid=0: no state change except lane drains.
- out_ready on a lane with out_valid=0 is ignored.

Decomposition:
- Package lane_dispatch_pkg holds:
  - localparam defaults NUM_LANES_DEF=5, DATA_W_DEF=8, CNT_W_DEF=16.
  - typedef lane_idx_t = logic [$clog2(NUM_LANES_DEF)-1:0].
  - function next_lane(idx, n) for the explicit wrap.
- Sub-module lane_dispatch_slot: one-entry register with load/drain/valid logic, instantiated NUM_LANES times.
- Selection priority logic and the counters stay in the top module.

Test Plan:
- Reset then 10 items 0x00..0x09 with all out_ready=1 -> items land on lanes 0,1,2,3,4,0,1,2,3,4 in order; disp_count=10; last_lane=4; in_ready=1 every cycle after reset.
- out_ready=5'b11101 (lane 1 stalled), fill lanes 0 and 1 with 0xA0, 0xA1, then send 0xB0..0xB3 -> lane 1 holds 0xA1 unchanged; the B items go to lanes 2, 3, 4, 0, skipping lane 1 while it is full.
- All out_ready=0, send 7 items -> first 5 accepted on lanes 0..4; in_ready=0 from cycle 6; then release out_ready[3] -> 6th item accepted on lane 3 in the same cycle as the lane 3 drain, with out_valid[3] staying 1.
- Preset disp_count to 0xFFFE by sending 65534 items, then send 3 more -> count reads 0xFFFF, then 0x0000, then 0x0001.
- Assert rst for 1 cycle while lanes 2 and 4 are full and in_valid=1 -> next cycle out_valid=0, disp_count=0, ptr=0; the next accept goes to lane 0.
- Randomised out_ready with in_valid held at 1 for 1000 cycles -> scoreboard shows no item lost or duplicated, per-lane order is preserved, and the payload is stable while stalled.

Source files
------------

// File: rtl/lane_dispatch_pkg.sv
// Shared definitions for the round-robin lane dispatcher.
//   NUM_LANES_DEF / DATA_W_DEF / CNT_W_DEF : default parameter values
//   lane_idx_t                             : lane index type for the default lane count
//   next_lane()                            : successor lane index with an explicit wrap
package lane_dispatch_pkg;

  localparam int NUM_LANES_DEF = 5;
  localparam int DATA_W_DEF    = 8;
  localparam int CNT_W_DEF     = 16;

  typedef logic [$clog2(NUM_LANES_DEF)-1:0] lane_idx_t;

  // Wraps by comparison rather than by masking, so lane counts that are not
  // powers of two cycle correctly.
  function automatic int unsigned next_lane(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/lane_dispatch_slot.sv
// One-entry output register for a single dispatcher lane.
//   clk     : clock
//   rst     : synchronous active-high reset, clears valid and data
//   i_load  : capture i_data this cycle (wins over a concurrent drain)
//   i_data  : payload to capture
//   i_ready : downstream ready for this lane
//   o_valid : lane holds an item
//   o_data  : held payload (keeps its last value after draining)
module lane_dispatch_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      // A reload in the same cycle as a drain replaces the old item.
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/lane_dispatch_rr.sv
// Round-robin dispatcher: spreads one valid/ready stream over NUM_LANES
// one-entry lanes, skipping lanes that are full and not draining.
//   clk        : clock
//   rst        : synchronous active-high reset
//   in_valid   : upstream item valid
//   in_data    : upstream payload
//   in_ready   : an item is accepted this cycle if in_valid is also high
//   out_valid  : per-lane valid, bit i = lane i
//   out_data   : per-lane payload, lane i at [i*DATA_W +: DATA_W]
//   out_ready  : per-lane downstream ready
//   disp_count : number of accepted items, wrapping
//   last_lane  : lane index of the most recently accepted item
module lane_dispatch_rr
  import lane_dispatch_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [NUM_LANES-1:0]        out_valid,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  input  logic [NUM_LANES-1:0]        out_ready,
  output logic [CNT_W-1:0]            disp_count,
  output logic [$clog2(NUM_LANES)-1:0] last_lane
);

  localparam int IDX_W = $clog2(NUM_LANES);

  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [IDX_W-1:0]     r_last;

  logic [NUM_LANES-1:0] w_free;
  logic [NUM_LANES-1:0] w_load;
  logic [IDX_W-1:0]     w_sel;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_found;
  logic                 w_accept;

  // A lane being drained this cycle can take a new item immediately.
  assign w_free = ~out_valid | out_ready;

  // Circular priority search starting at r_ptr. The sum carries one extra
  // bit so ptr+k never overflows before the explicit wrap.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_LANES)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_LANES);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && w_free[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign in_ready = w_found & ~rst;
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_load[gi] = w_accept && (w_sel == IDX_W'(gi));

      lane_dispatch_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (in_data),
        .i_ready (out_ready[gi]),
        .o_valid (out_valid[gi]),
        .o_data  (out_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else if (w_accept) begin
      r_ptr   <= IDX_W'(next_lane(32'(w_sel), 32'(NUM_LANES)));
      r_count <= r_count + 1'b1;
      r_last  <= w_sel;
    end
  end

  assign disp_count = r_count;
  assign last_lane  = r_last;

endmodule

// File: tb/tb_lane_dispatch_rr.sv
// Self-checking bench for lane_dispatch_rr: table-driven vectors, directed
// corner sequences, and a randomized run checked against a lane-level model
// plus a per-lane FIFO scoreboard.
module tb_lane_dispatch_rr;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [N-1:0]    out_valid;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_ready;
  logic [CW-1:0]   disp_count;
  logic [IW-1:0]   last_lane;

  always #5 clk = ~clk;

  lane_dispatch_rr #(.NUM_LANES(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .disp_count (disp_count),
    .last_lane  (last_lane)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: lane contents, rotation pointer, counters.
  bit   [N-1:0]  m_valid;
  logic [DW-1:0] m_data [N];
  int            m_ptr;
  int            m_count;
  int            m_last;

  // Scoreboard: per-lane FIFO of items routed there and not yet drained.
  logic [DW-1:0] sb_q [N][$];
  int            sb_accepted;
  int            sb_drained;

  logic          pre_ready;
  int            last_sel;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [N-1:0]  r;
    logic          exp_ready;
    logic [IW-1:0] exp_last;
    logic [CW-1:0] exp_count;
    logic [N-1:0]  exp_valid;
  } vec_t;

  vec_t vec [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Checks every registered output against the model.
  task automatic check_outputs(input string tag);
    logic [N*DW-1:0] ev;
    ev = '0;
    for (int i = 0; i < N; i++) ev[i*DW +: DW] = m_data[i];
    check({tag, "_out_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, "_out_data"}, 64'(out_data), 64'(ev));
    check({tag, "_disp_count"}, 64'(disp_count), 64'(m_count));
    check({tag, "_last_lane"}, 64'(last_lane), 64'(m_last));
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, clock,
  // advance the model and scoreboard, check outputs at the next falling edge.
  task automatic apply(input logic v, input logic [DW-1:0] d, input logic [N-1:0] r);
    int sel;
    logic [N*DW-1:0] data_pre;
    logic [N-1:0]    valid_pre;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    sel = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (sel < 0 && (!m_valid[idx] || r[idx])) sel = idx;
    end
    pre_ready = in_ready;
    check("in_ready", 64'(in_ready), 64'(sel >= 0));
    data_pre  = out_data;
    valid_pre = out_valid;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (valid_pre[i] && r[i]) begin
        if (sb_q[i].size() == 0) begin
          check("sb_underflow", 64'(i), 64'(N));
        end else begin
          check("sb_order", 64'(data_pre[i*DW +: DW]), 64'(sb_q[i].pop_front()));
          sb_drained++;
        end
      end
      if (m_valid[i] && r[i]) m_valid[i] = 1'b0;
    end
    last_sel = -1;
    if (v && sel >= 0) begin
      m_valid[sel] = 1'b1;
      m_data[sel]  = d;
      sb_q[sel].push_back(d);
      sb_accepted++;
      m_ptr   = (sel + 1) % N;
      m_count = (m_count + 1) % (1 << CW);
      m_last  = sel;
      last_sel = sel;
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic do_reset(input logic v, input logic [DW-1:0] d);
    rst       = 1'b1;
    in_valid  = v;
    in_data   = d;
    out_ready = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    m_valid = '0;
    for (int i = 0; i < N; i++) begin
      m_data[i] = '0;
      sb_q[i].delete();
    end
    m_ptr = 0; m_count = 0; m_last = 0;
    sb_accepted = 0; sb_drained = 0;
    @(negedge clk);
    rst = 1'b0;
    check_outputs("rst");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0;
    m_valid = '0; m_ptr = 0; m_count = 0; m_last = 0;
    sb_accepted = 0; sb_drained = 0; last_sel = -1; pre_ready = 1'b0;
    for (int i = 0; i < N; i++) m_data[i] = '0;

    // Expected lanes 0..4,0..4; only the freshly loaded lane is valid
    // because every other lane drains with out_ready all ones.
    vec[0] = '{1'b1, 8'h00, 5'h1F, 1'b1, 3'd0, 16'd1,  5'b00001};
    vec[1] = '{1'b1, 8'h01, 5'h1F, 1'b1, 3'd1, 16'd2,  5'b00010};
    vec[2] = '{1'b1, 8'h02, 5'h1F, 1'b1, 3'd2, 16'd3,  5'b00100};
    vec[3] = '{1'b1, 8'h03, 5'h1F, 1'b1, 3'd3, 16'd4,  5'b01000};
    vec[4] = '{1'b1, 8'h04, 5'h1F, 1'b1, 3'd4, 16'd5,  5'b10000};
    vec[5] = '{1'b1, 8'h05, 5'h1F, 1'b1, 3'd0, 16'd6,  5'b00001};
    vec[6] = '{1'b1, 8'h06, 5'h1F, 1'b1, 3'd1, 16'd7,  5'b00010};
    vec[7] = '{1'b1, 8'h07, 5'h1F, 1'b1, 3'd2, 16'd8,  5'b00100};
    vec[8] = '{1'b1, 8'h08, 5'h1F, 1'b1, 3'd3, 16'd9,  5'b01000};
    vec[9] = '{1'b1, 8'h09, 5'h1F, 1'b1, 3'd4, 16'd10, 5'b10000};

    @(negedge clk);
    do_reset(1'b0, 8'h00);

    // Table-driven round-robin with all lanes ready.
    for (int t = 0; t < 10; t++) begin
      apply(vec[t].v, vec[t].d, vec[t].r);
      $display("vec %0d: in=%02h lane=%0d count=%0d", t, vec[t].d, last_lane, disp_count);
      check("tbl_in_ready", 64'(pre_ready), 64'(vec[t].exp_ready));
      check("tbl_last_lane", 64'(last_lane), 64'(vec[t].exp_last));
      check("tbl_disp_count", 64'(disp_count), 64'(vec[t].exp_count));
      check("tbl_out_valid", 64'(out_valid), 64'(vec[t].exp_valid));
      check("tbl_out_data", 64'(out_data[(t%N)*DW +: DW]), 64'(vec[t].d));
    end

    // Lane 1 stalled: B items skip it while it holds 0xA1.
    apply(1'b0, 8'h00, 5'h1F);
    apply(1'b1, 8'hA0, 5'b11101);
    check("t2_a0_lane", 64'(last_lane), 64'(0));
    apply(1'b1, 8'hA1, 5'b11101);
    check("t2_a1_lane", 64'(last_lane), 64'(1));
    for (int b = 0; b < 4; b++) begin
      logic [IW-1:0] exp_lane;
      exp_lane = IW'((b + 2) % N);
      apply(1'b1, 8'(8'hB0 + b), 5'b11101);
      $display("t2 item %02h -> lane %0d", 8'hB0 + b, last_lane);
      check("t2_b_lane", 64'(last_lane), 64'(exp_lane));
      check("t2_l1_valid", 64'(out_valid[1]), 64'(1));
      check("t2_l1_data", 64'(out_data[1*DW +: DW]), 64'(8'hA1));
    end
    apply(1'b0, 8'h00, 5'h1F);

    // All lanes stalled: five accepted, then backpressure, then lane 3 frees.
    do_reset(1'b0, 8'h00);
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 8'(8'hC0 + c), 5'b00000);
      check("t3_fill_lane", 64'(last_lane), 64'(c));
    end
    apply(1'b1, 8'hC5, 5'b00000);
    check("t3_stall_ready", 64'(pre_ready), 64'(0));
    check("t3_stall_count", 64'(disp_count), 64'(5));
    apply(1'b1, 8'hC5, 5'b01000);
    check("t3_drain_ready", 64'(pre_ready), 64'(1));
    check("t3_reload_lane", 64'(last_lane), 64'(3));
    check("t3_reload_valid", 64'(out_valid), 64'(5'h1F));
    check("t3_reload_data", 64'(out_data[3*DW +: DW]), 64'(8'hC5));
    apply(1'b1, 8'hC6, 5'b00000);
    check("t3_c6_blocked", 64'(disp_count), 64'(6));
    apply(1'b1, 8'hC6, 5'h1F);

    // Reset while lanes 2 and 4 are full and in_valid is high.
    do_reset(1'b0, 8'h00);
    for (int c = 0; c < 5; c++) apply(1'b1, 8'(8'hD0 + c), 5'b00000);
    apply(1'b0, 8'h00, 5'b01011);
    check("t5_pre_valid", 64'(out_valid), 64'(5'b10100));
    do_reset(1'b1, 8'hEE);
    check("t5_post_valid", 64'(out_valid), 64'(0));
    check("t5_post_count", 64'(disp_count), 64'(0));
    apply(1'b1, 8'h55, 5'h1F);
    check("t5_first_lane", 64'(last_lane), 64'(0));
    check("t5_first_valid", 64'(out_valid), 64'(5'b00001));

    // Counter wrap.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 65534; i++) apply(1'b1, 8'(i), 5'h1F);
    check("t4_preset", 64'(disp_count), 64'(16'hFFFE));
    apply(1'b1, 8'h01, 5'h1F);
    check("t4_ffff", 64'(disp_count), 64'(16'hFFFF));
    apply(1'b1, 8'h02, 5'h1F);
    check("t4_wrap0", 64'(disp_count), 64'(16'h0000));
    apply(1'b1, 8'h03, 5'h1F);
    check("t4_wrap1", 64'(disp_count), 64'(16'h0001));

    // Randomized backpressure with a continuous input stream.
    do_reset(1'b0, 8'h00);
    for (int i = 0; i < 1000; i++) apply(1'b1, 8'($urandom), 5'($urandom));
    apply(1'b0, 8'h00, 5'h1F);
    check("t6_all_drained", 64'(out_valid), 64'(0));
    check("t6_conserve", 64'(sb_drained), 64'(sb_accepted));
    for (int i = 0; i < N; i++) check("t6_queue_empty", 64'(sb_q[i].size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
